// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types for the transform engine and its job arbiter
package sha256_pkg;
    typedef struct packed {
        logic [7:0][31:0] h;
    } ShaContext;
    typedef logic [15:0][31:0] ShaChunk;
    typedef enum logic [1:0] {IDLE, CTX, RUN, RESP} ArbState;
endpackage

// File: rtl/sha256_job_arbiter_rr.sv
// rr_arbiter: picks the first requester at or after ptr, wrapping, as one-hot and id
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);
    logic [IDW-1:0] idx;
    // Scan from the farthest offset back toward ptr so the closest requester wins
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (req[idx]) begin
                grant    = NREQ'(1) << idx;
                grant_id = idx;
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sha256_job_arbiter.sv
// sha256_job_arbiter: locks one sha256 transform engine to a requester for a whole job
module sha256_job_arbiter
    import sha256_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_ctx_vld,
    output logic [NREQ-1:0]      req_ctx_rdy,
    input  ShaContext [NREQ-1:0] req_ctx,
    input  logic [NREQ-1:0]      req_chunk_vld,
    output logic [NREQ-1:0]      req_chunk_rdy,
    input  ShaChunk [NREQ-1:0]   req_chunk,
    output logic [NREQ-1:0]      req_hash_vld,
    input  logic [NREQ-1:0]      req_hash_rdy,
    output logic [255:0]         req_hash,
    output logic                 eng_ctx_vld,
    input  logic                 eng_ctx_rdy,
    output ShaContext            eng_ctx,
    output logic                 eng_chunk_vld,
    input  logic                 eng_chunk_rdy,
    output ShaChunk              eng_chunk,
    input  logic                 eng_hash_vld,
    output logic                 eng_hash_rdy,
    input  logic [255:0]         eng_hash,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic [CNTW-1:0]      job_chunks
);
    ArbState         state, state_nxt;
    logic [IDW-1:0]  rr_ptr, arb_id;
    logic [NREQ-1:0] arb_grant, owner;
    logic            arb_any, ctx_hs, chunk_hs, hash_hs;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req      (req_ctx_vld),
        .ptr      (rr_ptr),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    assign ctx_hs    = eng_ctx_vld & eng_ctx_rdy;
    assign chunk_hs  = eng_chunk_vld & eng_chunk_rdy;
    assign hash_hs   = eng_hash_vld & eng_hash_rdy;
    assign eng_ctx   = req_ctx[grant_id];
    assign eng_chunk = req_chunk[grant_id];
    assign req_hash  = eng_hash;
    assign busy      = state != IDLE;

    // Job phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Advance through the job phases on each handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = arb_any  ? CTX  : IDLE;
            CTX:     state_nxt = ctx_hs   ? RUN  : CTX;
            RUN:     state_nxt = eng_hash_vld ? RESP : RUN;
            default: state_nxt = hash_hs  ? IDLE : RESP;
        endcase
    end

    // Steer handshakes to the locked owner only; every other requester sees zeros
    always_comb begin
        eng_ctx_vld   = (state == CTX) && |(req_ctx_vld & owner);
        req_ctx_rdy   = (state == CTX) ? owner & {NREQ{eng_ctx_rdy}} : '0;
        eng_chunk_vld = (state == RUN) && |(req_chunk_vld & owner);
        req_chunk_rdy = (state == RUN) ? owner & {NREQ{eng_chunk_rdy}} : '0;
        req_hash_vld  = (state == RESP) ? owner & {NREQ{eng_hash_vld}} : '0;
        eng_hash_rdy  = (state == RESP) && |(req_hash_rdy & owner);
    end

    // Grant lock, saturating chunk count, and pointer hand-off after each hash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            owner      <= '0;
            job_chunks <= '0;
        end else begin
            if (state == IDLE && arb_any) begin
                grant_id   <= arb_id;
                owner      <= arb_grant;
                job_chunks <= '0;
            end
            if (chunk_hs && !(&job_chunks)) job_chunks <= job_chunks + 1'b1;
            if (hash_hs) rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end
endmodule
